// File: rtl/dmem_arb_pkg.sv
// Shared constants and the address check used by the data-memory arbiter.
package dmem_arb_pkg;

  localparam int          PORT_CPU      = 0;
  localparam int          PORT_DMA      = 1;
  localparam int unsigned MEM_WORDS_DEF = 256;
  localparam int          ADDR_W_MAX    = 64;

  // Addresses arrive zero-extended to ADDR_W_MAX so the check is width independent.
  function automatic logic is_bad_addr(input logic [ADDR_W_MAX-1:0] addr,
                                       input int unsigned            words);
    return (addr[1:0] != 2'b00) || (addr[ADDR_W_MAX-1:2] >= {30'd0, words});
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer only moves when both ports request.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic rr_ptr_q, rr_ptr_d;
  logic conflict;

  assign conflict = &req_i;

  always_comb begin
    gnt_o    = req_i;
    rr_ptr_d = rr_ptr_q;
    if (conflict) begin
      gnt_o    = rr_ptr_q ? 2'b10 : 2'b01;
      rr_ptr_d = ~rr_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_ptr_q <= 1'b0;
    else        rr_ptr_q <= rr_ptr_d;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester front end for the single-port data memory: grant, memory drive,
// one-cycle registered responses and a saturating conflict counter.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_rsp_valid,
  output logic [DATA_W-1:0] m0_rsp_rdata,
  output logic              m0_rsp_err,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_rsp_valid,
  output logic [DATA_W-1:0] m1_rsp_rdata,
  output logic              m1_rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       conflict_cnt
);

  logic [1:0]             req, gnt, we, err;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][DATA_W-1:0] wdata;
  logic [1:0]             rsp_valid, rsp_err;
  logic [1:0][DATA_W-1:0] rsp_rdata;

  assign req   = {m1_valid, m0_valid};
  assign we    = {m1_we, m0_we};
  assign addr  = {m1_addr, m0_addr};
  assign wdata = {m1_wdata, m0_wdata};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req),
    .gnt_o (gnt)
  );

  assign m0_ready = gnt[PORT_CPU];
  assign m1_ready = gnt[PORT_DMA];

  // Grant is one-hot, so OR-ing the granted lane onto the pins is safe.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < 2; i++) begin
      if (gnt[i]) begin
        mem_read  = ~we[i] & ~err[i];
        mem_write =  we[i] & ~err[i];
        mem_addr  = addr[i];
        mem_wdata = wdata[i];
      end
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_port
    logic              vld_q, err_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    assign err[i]  = is_bad_addr(ADDR_W_MAX'(addr[i]), MEM_WORDS);
    assign rdata_d = (~we[i] & ~err[i]) ? mem_rdata : '0;

    // Losing / idle port keeps its last data and error flag.
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        vld_q   <= 1'b0;
        err_q   <= 1'b0;
        rdata_q <= '0;
      end else begin
        vld_q <= gnt[i];
        if (gnt[i]) begin
          err_q   <= err[i];
          rdata_q <= rdata_d;
        end
      end

    assign rsp_valid[i] = vld_q;
    assign rsp_err[i]   = err_q;
    assign rsp_rdata[i] = rdata_q;
  end

  assign m0_rsp_valid = rsp_valid[PORT_CPU];
  assign m0_rsp_err   = rsp_err[PORT_CPU];
  assign m0_rsp_rdata = rsp_rdata[PORT_CPU];
  assign m1_rsp_valid = rsp_valid[PORT_DMA];
  assign m1_rsp_err   = rsp_err[PORT_DMA];
  assign m1_rsp_rdata = rsp_rdata[PORT_DMA];

  logic [15:0] cnt_q, cnt_d;

  assign cnt_d = (&req && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: memory model, reference arbiter model and response scoreboard.
module tb_dmem_arbiter;

  logic        clk, rst_n;
  logic        m0_valid, m0_ready, m0_we, m0_rsp_valid, m0_rsp_err;
  logic [31:0] m0_addr, m0_wdata, m0_rsp_rdata;
  logic        m1_valid, m1_ready, m1_we, m1_rsp_valid, m1_rsp_err;
  logic [31:0] m1_addr, m1_wdata, m1_rsp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] conflict_cnt;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
    .m0_rsp_err(m0_rsp_err),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
    .m1_rsp_err(m1_rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard entries are {err, rdata}, pushed at accept, popped one cycle later.
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [1:0]  pend;
  logic        m_ptr;
  logic [15:0] m_cnt;

  always @(negedge clk) begin
    logic [1:0]  v, g;
    logic        k, w, e, x_rd, x_wr;
    logic [31:0] a, d, rd, x_a, x_d;
    logic [32:0] ent;
    if (!rst_n) begin
      chk("rst_rsp_valid0", 64'(m0_rsp_valid), 64'd0);
      chk("rst_rsp_valid1", 64'(m1_rsp_valid), 64'd0);
      chk("rst_cnt", 64'(conflict_cnt), 64'd0);
      q0.delete(); q1.delete();
      pend = 2'b00; m_ptr = 1'b0; m_cnt = 16'd0;
    end else begin
      if (pend[0]) begin
        ent = q0.pop_front();
        chk("rsp0_valid", 64'(m0_rsp_valid), 64'd1);
        chk("rsp0_rdata", 64'(m0_rsp_rdata), 64'(ent[31:0]));
        chk("rsp0_err", 64'(m0_rsp_err), 64'(ent[32]));
      end else chk("rsp0_idle", 64'(m0_rsp_valid), 64'd0);
      if (pend[1]) begin
        ent = q1.pop_front();
        chk("rsp1_valid", 64'(m1_rsp_valid), 64'd1);
        chk("rsp1_rdata", 64'(m1_rsp_rdata), 64'(ent[31:0]));
        chk("rsp1_err", 64'(m1_rsp_err), 64'(ent[32]));
      end else chk("rsp1_idle", 64'(m1_rsp_valid), 64'd0);
      chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));

      v = {m1_valid, m0_valid};
      g = (&v) ? (m_ptr ? 2'b10 : 2'b01) : v;
      chk("ready0", 64'(m0_ready), 64'(g[0]));
      chk("ready1", 64'(m1_ready), 64'(g[1]));
      x_rd = 1'b0; x_wr = 1'b0; x_a = '0; x_d = '0;
      if (g != 2'b00) begin
        k  = g[1];
        a  = k ? m1_addr  : m0_addr;
        d  = k ? m1_wdata : m0_wdata;
        w  = k ? m1_we    : m0_we;
        e  = (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
        rd = (!w && !e) ? ref_mem[a[9:2]] : 32'd0;
        if (w && !e) ref_mem[a[9:2]] = d;
        x_rd = !w && !e; x_wr = w && !e; x_a = a; x_d = d;
        if (k) q1.push_back({e, rd}); else q0.push_back({e, rd});
        if (&v) m_ptr = ~k;
      end
      chk("mem_read", 64'(mem_read), 64'(x_rd));
      chk("mem_write", 64'(mem_write), 64'(x_wr));
      chk("mem_addr", 64'(mem_addr), 64'(x_a));
      chk("mem_wdata", 64'(mem_wdata), 64'(x_d));
      pend = g;
      if (&v && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  end

  // Applies one cycle of request inputs; returns 1 time unit after the accepting edge.
  task automatic req(input logic v0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic v1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    m0_valid = v0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_valid = v1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    req(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = 32'd0; ref_mem[i] = 32'd0; end
    mem[0] = 32'hDEADBEEF; ref_mem[0] = 32'hDEADBEEF;
    mem[1] = 32'hCAFEBABE; ref_mem[1] = 32'hCAFEBABE;
    rst_n = 1'b0;
    m0_valid = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_valid = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Port 0 alone, load word 0
    req(1, 0, 32'h0, 0, 0, 0, 0, 0);
    chk("p0_load_valid", 64'(m0_rsp_valid), 64'd1);
    chk("p0_load_rdata", 64'(m0_rsp_rdata), 64'hDEADBEEF);
    chk("p0_load_err", 64'(m0_rsp_err), 64'd0);
    idle();

    // Conflict moves pointer to port 1, then reset lands right after a load is accepted
    req(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
    idle();
    req(1, 0, 32'h4, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    m0_valid = 0; m1_valid = 0;
    #1;
    chk("midrst_rsp_valid0", 64'(m0_rsp_valid), 64'd0);
    chk("midrst_cnt", 64'(conflict_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Four conflict cycles: first grant must be port 0 again
    m0_valid = 1; m0_we = 0; m0_addr = 32'h0;
    m1_valid = 1; m1_we = 0; m1_addr = 32'h4;
    #1;
    chk("post_rst_gnt0", 64'(m0_ready), 64'd1);
    chk("post_rst_gnt1", 64'(m1_ready), 64'd0);
    @(posedge clk); #1;
    repeat (3) req(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
    chk("conflict4_cnt", 64'(conflict_cnt), 64'd4);
    chk("p1_cafebabe", 64'(m1_rsp_rdata), 64'hCAFEBABE);
    idle();

    // Store from port 1 then load from port 0 on the next cycle
    req(0, 0, 0, 0, 1, 1, 32'h8, 32'h12345678);
    chk("p1_store_ack", 64'(m1_rsp_rdata), 64'd0);
    req(1, 0, 32'h8, 0, 0, 0, 0, 0);
    chk("raw_rdata", 64'(m0_rsp_rdata), 64'h12345678);

    // Misaligned and out-of-range requests
    req(1, 0, 32'h6, 0, 0, 0, 0, 0);
    chk("misalign_err", 64'(m0_rsp_err), 64'd1);
    chk("misalign_rdata", 64'(m0_rsp_rdata), 64'd0);
    req(1, 0, 32'h400, 0, 0, 0, 0, 0);
    chk("range_err", 64'(m0_rsp_err), 64'd1);
    req(1, 1, 32'h404, 32'hFFFF0000, 0, 0, 0, 0);
    chk("range_store_err", 64'(m0_rsp_err), 64'd1);
    idle();
    chk("mem0_intact", 64'(mem[0]), 64'hDEADBEEF);

    // Saturation of the conflict counter
    repeat (70000) req(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
    chk("cnt_saturate", 64'(conflict_cnt), 64'hFFFF);
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
